// File: rtl/pipeline_mem_lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: FSM states, access sizes,
// byte-enable patterns and small decode helpers.
package pipeline_mem_lsu_pkg;

  typedef enum logic [1:0] {StIdle, StReq, StResp, StDone} lsu_state_e;
  typedef enum logic [1:0] {SizeByte, SizeHalf, SizeWord} lsu_size_e;

  localparam logic [3:0] BeByte = 4'b0001;
  localparam logic [3:0] BeHalf = 4'b0011;
  localparam logic [3:0] BeWord = 4'b1111;

  // Byte select overrides half select.
  function automatic lsu_size_e decode_size(input logic half_sel, input logic byte_sel);
    if (byte_sel) return SizeByte;
    if (half_sel) return SizeHalf;
    return SizeWord;
  endfunction

  function automatic logic is_misaligned(input lsu_size_e size, input logic [1:0] off);
    unique case (size)
      SizeHalf: return off[0];
      SizeWord: return off != 2'b00;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/pipeline_mem_lsu_if.sv
// Data bus between the load/store unit (master) and memory (slave): req/gnt/rvalid handshake.
interface pipeline_mem_lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;

  modport master (output req, we, addr, be, wdata, input gnt, rvalid, rdata);
  modport slave  (input req, we, addr, be, wdata, output gnt, rvalid, rdata);
endinterface

// File: rtl/pipeline_mem_lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, load lane select and extend.
module pipeline_mem_lsu_align
  import pipeline_mem_lsu_pkg::*;
(
  input  lsu_size_e   size_i,
  input  logic        sign_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [7:0]  lane8;
  logic [15:0] lane16;

  always_comb begin
    be_o    = BeWord;
    wdata_o = wdata_i;
    rdata_o = rdata_i;
    lane8   = rdata_i[{off_i, 3'b000} +: 8];
    lane16  = rdata_i[{off_i[1], 4'b0000} +: 16];
    unique case (size_i)
      SizeByte: begin
        be_o    = BeByte << off_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{sign_i & lane8[7]}}, lane8};
      end
      SizeHalf: begin
        be_o    = BeHalf << {off_i[1], 1'b0};
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{sign_i & lane16[15]}}, lane16};
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipeline_mem_lsu.sv
// Memory-stage load/store unit: captures the MEM-stage access, runs one bus transaction,
// stalls the pipeline meanwhile and reports misalignment and bus timeouts.
module pipeline_mem_lsu
  import pipeline_mem_lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mem_read_i,
  input  logic                       mem_write_i,
  input  logic                       half_i,
  input  logic                       byte_i,
  input  logic                       sign_i,
  input  logic [31:0]                addr_i,
  input  logic [31:0]                wdata_i,
  pipeline_mem_lsu_if.master         dbus,
  output logic                       stall_o,
  output logic [31:0]                load_data_o,
  output logic                       misalign_o,
  output logic                       bus_err_o
);

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYC - 1);

  lsu_state_e  state_q, state_d;
  lsu_size_e   size_q, size_d, size_in;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, load_data_q, load_data_d;
  logic        sign_q, sign_d, we_q, we_d, misalign_q, misalign_d, bus_err_q, bus_err_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        op_valid, timeout, req;
  logic [3:0]  be;
  logic [31:0] wdata_lane, rdata_ext;

  assign op_valid = mem_read_i | mem_write_i;
  assign size_in  = decode_size(half_i, byte_i);
  assign timeout  = cnt_q == TimeoutLast;

  pipeline_mem_lsu_align u_align (
    .size_i  (size_q),
    .sign_i  (sign_q),
    .off_i   (addr_q[1:0]),
    .wdata_i (wdata_q),
    .rdata_i (dbus.rdata),
    .be_o    (be),
    .wdata_o (wdata_lane),
    .rdata_o (rdata_ext)
  );

  always_comb begin
    state_d     = state_q;
    size_d      = size_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    sign_d      = sign_q;
    we_d        = we_q;
    cnt_d       = cnt_q;
    load_data_d = load_data_q;
    misalign_d  = 1'b0;
    bus_err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (op_valid) begin
          size_d  = size_in;
          addr_d  = addr_i;
          wdata_d = wdata_i;
          sign_d  = sign_i;
          we_d    = mem_write_i;
          if (is_misaligned(size_in, addr_i[1:0])) begin
            state_d    = StDone;
            misalign_d = 1'b1;
          end else begin
            state_d = StReq;
            cnt_d   = '0;
          end
        end
      end
      StReq, StResp: begin
        cnt_d = cnt_q + 8'd1;
        if (state_q == StReq && dbus.gnt) begin
          state_d = we_q ? StDone : StResp;
        end else if (state_q == StResp && dbus.rvalid) begin
          state_d     = StDone;
          load_data_d = rdata_ext;
        end else if (timeout) begin
          state_d   = StDone;
          bus_err_d = 1'b1;
          if (!we_q) load_data_d = '0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      size_q      <= SizeByte;
      addr_q      <= '0;
      wdata_q     <= '0;
      sign_q      <= 1'b0;
      we_q        <= 1'b0;
      cnt_q       <= '0;
      load_data_q <= '0;
      misalign_q  <= 1'b0;
      bus_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      size_q      <= size_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      sign_q      <= sign_d;
      we_q        <= we_d;
      cnt_q       <= cnt_d;
      load_data_q <= load_data_d;
      misalign_q  <= misalign_d;
      bus_err_q   <= bus_err_d;
    end
  end

  // Payload is driven only while requesting so the bus idles at zero.
  assign req        = state_q == StReq;
  assign dbus.req   = req;
  assign dbus.we    = req & we_q;
  assign dbus.addr  = req ? {addr_q[31:2], 2'b00} : '0;
  assign dbus.be    = req ? be : '0;
  assign dbus.wdata = req ? wdata_lane : '0;

  // Gated by rst_n so a held-over op cannot keep the pipeline frozen during reset.
  assign stall_o = rst_n & ((state_q == StIdle & op_valid) | state_q == StReq |
                            state_q == StResp);
  assign load_data_o = load_data_q;
  assign misalign_o  = misalign_q;
  assign bus_err_o   = bus_err_q;

endmodule

// File: doc/pipeline_mem_lsu.md
# pipeline_mem_lsu

Memory-stage load/store unit for the forwarding RISC-V pipeline. Consumes the EX/MEM-registered ALU result (address), forwarded store data and the Half/Byte/Sign load qualifiers. Drives a req/gnt/rvalid data bus with byte enables, and returns an aligned, sign- or zero-extended load result to MEM/WB. Stalls the pipeline while a bus transaction is outstanding, and flags misaligned accesses and bus timeouts.

## Interface
- `TIMEOUT_CYC`, default 64: cycles allowed in REQ+RESP before the access is abandoned; range 2..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `mem_read_i` in 1: load in MEM stage.
- `mem_write_i` in 1: store in MEM stage; has priority if both are set.
- `half_i`, `byte_i`, `sign_i` in 1 each: access size (neither = word) and load sign-extend. `byte_i` wins if both size bits are set.
- `addr_i` in 32: effective address (EX ALU result).
- `wdata_i` in 32: store data, already forwarded.
- `dbus_req_o` out 1: request; held until `dbus_gnt_i`.
- `dbus_we_o` out 1: 1 = store.
- `dbus_addr_o` out 32: `{addr[31:2],2'b00}`.
- `dbus_be_o` out 4: byte enables.
- `dbus_wdata_o` out 32: lane-replicated store data.
- `dbus_gnt_i` in 1: request accepted.
- `dbus_rvalid_i` in 1: read data valid; earliest one cycle after gnt.
- `dbus_rdata_i` in 32: read data.
- `stall_o` out 1: freeze IF..MEM while 1.
- `load_data_o` out 32: extended load result; holds its value until the next load completes.
- `misalign_o` out 1: one-cycle pulse on misaligned access.
- `bus_err_o` out 1: one-cycle pulse on timeout.

## Operation
- **FSM states:** IDLE, REQ, RESP, DONE.
- **IDLE:**
  - When `mem_read_i|mem_write_i` is set: capture addr, wdata, size, sign and we into internal registers; `stall_o`=1 combinationally.
  - Aligned access → REQ. Misaligned access → DONE with `misalign_o` set for the DONE cycle; no bus request is issued.
- **Misaligned:** half with addr[0]=1; word with addr[1:0]≠0.
- **REQ:** `dbus_req_o`=1 with a stable captured payload.
  - On gnt: store → DONE; load → RESP.
- **RESP:** waits for `dbus_rvalid_i`, then captures extended data into `load_data_o` → DONE.
- **DONE:** `stall_o`=0 so the pipeline advances at the end of this cycle. Unconditionally → IDLE; the stale inputs visible in DONE are never re-issued.
- **Timeout:** counter clears on entry to REQ and increments in REQ and RESP. When it reaches `TIMEOUT_CYC` → DONE with `bus_err_o` set; a load writes 0 into `load_data_o`. A late rvalid arriving in IDLE or DONE is ignored.
- **Byte enables:**
  - byte: `4'b0001<<addr[1:0]`
  - half: `4'b0011<<{addr[1],1'b0}`
  - word: `4'hF`
- **Store data:** byte → `{4{wdata[7:0]}}`; half → `{2{wdata[15:0]}}`; word → as is.
- **Load extraction:** byte lane `rdata[8*addr[1:0]+:8]`; half lane `rdata[16*addr[1]+:16]`. Bit 7 or 15 is replicated when `sign_i`=1, else zero-filled.
- **Reset:** state IDLE, counter 0, all outputs 0 including `load_data_o`. Asserting `rst_n`=0 mid-transaction drops `dbus_req_o` immediately (asynchronously).

## Timing
- `stall_o` = (state==IDLE & op valid) | state∈{REQ,RESP}.
- Store, zero-wait: c0 IDLE (stall=1), c1 REQ + gnt (stall=1), c2 DONE (stall=0). Two stall cycles.
- Load, zero-wait: c0 IDLE, c1 REQ + gnt, c2 RESP + rvalid, c3 DONE. Three stall cycles; `load_data_o` is valid from c3.
- Misaligned: c0 IDLE, c1 DONE with pulse. One stall cycle.
- Each gnt wait cycle and each rvalid wait cycle adds exactly one stall cycle.
- No op in IDLE: `stall_o`=0 and no bus activity.
- The upstream stage must hold all inputs stable while `stall_o`=1; the unit samples them only in IDLE.

## Structure
- Shared header `lsu_defs`: state encodings, size codes (BYTE/HALF/WORD), BE constants.
- Sub-module `lsu_align`: combinational BE generation, store lane replication, and load lane select/extend. The FSM, capture registers and timeout counter stay in the top module.

## Test plan
- **sb:** addr 0x1003, wdata 0x000000AB, gnt in REQ → be=4'b1000, wdata_o=0xABABABAB, `dbus_addr_o`=0x1000, stall high exactly 2 cycles.
- **lb signed:** addr 0x2001, rdata 0x00F08000, sign=1, gnt then rvalid → `load_data_o`=0xFFFFFF80, stall 3 cycles. Same access with sign=0 → 0x00000080.
- **lhu with delays:** addr 0x2002, gnt held off 3 cycles, rvalid after a further 2 cycles, rdata 0x8765xxxx → `load_data_o`=0x00008765, stall 3+3+2=8 cycles.
- **Misaligned lw:** addr 0x3002 → no `dbus_req_o`, `misalign_o` pulses in c1, stall 1 cycle.
- **Timeout:** with `TIMEOUT_CYC`=4 and gnt never asserted → `bus_err_o` pulse, load data 0. A subsequent rvalid in IDLE leaves `load_data_o` at 0.
- **Async reset mid-RESP:** `rst_n` low → `dbus_req_o`/`stall_o` go 0 without waiting for a clock edge. After release: IDLE, and the next op behaves as from reset.
